conv_mac_engine: RTL

Parametrised multiply-accumulate core for the CNN convolution layer. Computes one output pixel per job: it sums masked K×K window·filter dot products over a configurable number of input channels, adds a bias, rescales in Q(DATA_W−FRAC_W).FRAC_W fixed point with rounding and saturation, and optionally applies ReLU. It sits between the load path (window/filter operands) and the write path (result to CNNmemory). It supports kernel sizes 1..K_MAX at runtime, channel streaming with a valid/ready handshake, and output backpressure.

---
 rtl/cnn_pkg.sv | 47 ++++
 rtl/conv_tap_tree.sv | 68 ++++++
 rtl/conv_mac_engine.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   conv_state_t : convolution engine FSM encoding
//   round_t      : result of sat_round (clipped value + clip flag)
//   sat_round    : round-half-up, arithmetic shift, saturate to a signed width
package cnn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_FINAL = 3'd3,
        S_OUT   = 3'd4
    } conv_state_t;

    typedef struct packed {
        logic [63:0] value;
        logic        sat;
    } round_t;

    // t is a Q(.fracW) value held in 64 bits; the result is an integer-scaled
    // value clipped into a signed dataW range, sign-extended to 64 bits.
    function automatic round_t sat_round(input logic signed [63:0] t,
                                         input int fracW,
                                         input int dataW);
        logic signed [63:0] r;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        round_t o;
        r    = (t + (64'sd1 <<< (fracW - 1))) >>> fracW;
        maxV = (64'sd1 <<< (dataW - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (dataW - 1));
        o.sat   = 1'b0;
        o.value = r;
        if (r > maxV) begin
            o.value = maxV;
            o.sat   = 1'b1;
        end else if (r < minV) begin
            o.value = minV;
            o.sat   = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/conv_tap_tree.sv
// Masked K_MAX x K_MAX multiplier array plus adder tree, two pipeline stages.
//   clk, reset      : clock, synchronous active-low reset
//   inValid         : a window/weights pair enters this cycle
//   kernelSize      : active kernel edge (already legalised, 1..K_MAX)
//   window, weights : row-major taps, tap i at [i*DATA_W +: DATA_W]
//   s1Valid         : product stage holds a pair
//   s2Valid, sum    : registered sum of the masked products
module conv_tap_tree #(
    parameter int DATA_W = 16,
    parameter int K_MAX  = 5,
    parameter int SUM_W  = 2 * DATA_W + $clog2(K_MAX * K_MAX)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inValid,
    input  logic [2:0]                      kernelSize,
    input  logic [K_MAX*K_MAX*DATA_W-1:0]   window,
    input  logic [K_MAX*K_MAX*DATA_W-1:0]   weights,
    output logic                            s1Valid,
    output logic                            s2Valid,
    output logic signed [SUM_W-1:0]         sum
);

    localparam int TAPS   = K_MAX * K_MAX;
    localparam int PROD_W = 2 * DATA_W;

    logic [TAPS-1:0]            tapMask;
    logic signed [PROD_W-1:0]   prodReg [TAPS];
    logic signed [SUM_W-1:0]    treeSum;

    // Tap (r,c) lives at index r*K_MAX+c; only the top-left k x k square counts.
    always_comb begin
        tapMask = '0;
        for (int i = 0; i < TAPS; i++) begin
            tapMask[i] = ((i / K_MAX) < int'(kernelSize)) &&
                         ((i % K_MAX) < int'(kernelSize));
        end
    end

    always_comb begin
        treeSum = '0;
        for (int i = 0; i < TAPS; i++) begin
            treeSum = treeSum + SUM_W'(prodReg[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            sum     <= '0;
            for (int i = 0; i < TAPS; i++) prodReg[i] <= '0;
        end else begin
            s1Valid <= inValid;
            s2Valid <= s1Valid;
            if (inValid) begin
                for (int i = 0; i < TAPS; i++) begin
                    prodReg[i] <= tapMask[i]
                        ? PROD_W'($signed(window[i*DATA_W +: DATA_W]) *
                                  $signed(weights[i*DATA_W +: DATA_W]))
                        : '0;
                end
            end
            if (s1Valid) sum <= treeSum;
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// One-output-pixel convolution MAC: streams channel pairs through the tap
// tree, accumulates, adds bias, rescales with rounding/saturation, optional ReLU.
//   clk, reset                        : clock, synchronous active-low reset
//   start, kernel_size, num_channels,
//   bias, relu_en                     : job start and config, latched in IDLE
//   in_valid/in_ready, window/weights : operand stream
//   out_valid/out_ready, out_data/sat : result, held until accepted
//   cfg_err, busy, done               : status
//   dbgState                          : current FSM state
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid && ready; the producer holds valid and data stable until then, and
// ready never depends combinationally on valid.
module conv_mac_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int K_MAX  = 5,
    parameter int ACC_W  = 40
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [2:0]                      kernel_size,
    input  logic [15:0]                     num_channels,
    input  logic [DATA_W-1:0]               bias,
    input  logic                            relu_en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [K_MAX*K_MAX*DATA_W-1:0]   window,
    input  logic [K_MAX*K_MAX*DATA_W-1:0]   weights,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            sat,
    output logic                            cfg_err,
    output logic                            busy,
    output logic                            done,
    output conv_state_t                     dbgState
);

    localparam int SUM_W = 2 * DATA_W + $clog2(K_MAX * K_MAX);

    conv_state_t                state;
    logic [15:0]                count;
    logic [15:0]                numCh;
    logic [2:0]                 kEff;
    logic signed [DATA_W-1:0]   biasReg;
    logic                       reluReg;
    logic signed [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]          outData;
    logic                       satReg;
    logic                       cfgErr;

    logic                       accept;
    logic                       badK;
    logic                       s1Valid;
    logic                       s2Valid;
    logic signed [SUM_W-1:0]    sum;
    logic signed [63:0]         tWide;
    round_t                     rnd;
    logic [DATA_W-1:0]          finalData;

    assign in_ready  = (state == S_ACCUM) && (count < numCh);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_OUT);
    assign done      = (state == S_OUT) && out_ready;
    assign busy      = (state != S_IDLE);
    assign out_data  = outData;
    assign sat       = satReg;
    assign cfg_err   = cfgErr;
    assign dbgState  = state;
    assign badK      = (kernel_size == 3'd0) || (int'(kernel_size) > K_MAX);

    conv_tap_tree #(
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX),
        .SUM_W  (SUM_W)
    ) u_tapTree (
        .clk        (clk),
        .reset      (reset),
        .inValid    (accept),
        .kernelSize (kEff),
        .window     (window),
        .weights    (weights),
        .s1Valid    (s1Valid),
        .s2Valid    (s2Valid),
        .sum        (sum)
    );

    // Bias is aligned to the Q.FRAC_W*2 product scale before rounding back down.
    always_comb begin
        tWide     = 64'(acc) + (64'(biasReg) <<< FRAC_W);
        rnd       = sat_round(tWide, FRAC_W, DATA_W);
        finalData = rnd.value[DATA_W-1:0];
        if (reluReg && ($signed(rnd.value) < 64'sd0)) finalData = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            numCh   <= '0;
            kEff    <= '0;
            biasReg <= '0;
            reluReg <= 1'b0;
            acc     <= '0;
            outData <= '0;
            satReg  <= 1'b0;
            cfgErr  <= 1'b0;
        end else begin
            // S3: the pipeline is empty in IDLE, so clearing on start never races an add.
            if (s2Valid) acc <= acc + ACC_W'(sum);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        numCh   <= num_channels;
                        kEff    <= badK ? 3'(K_MAX) : kernel_size;
                        biasReg <= bias;
                        reluReg <= relu_en;
                        cfgErr  <= badK;
                        count   <= '0;
                        acc     <= '0;
                        state   <= (num_channels == 16'd0) ? S_FINAL : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        count <= count + 16'd1;
                        if (count + 16'd1 == numCh) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last add lands in acc on the edge s2Valid falls.
                    if (!s1Valid && !s2Valid) state <= S_FINAL;
                end
                S_FINAL: begin
                    outData <= finalData;
                    satReg  <= rnd.sat;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
